// File: rtl/mux8_rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// mux8_rr_arbiter_if
// Bundle of the requester, consumer and grant signals around the shared
// mux8 round-robin arbiter.
//   req       : per-requester request bits (req[i] = requester i has a word)
//   d0..d7    : requester data words, WIDTH bits each
//   out_ready : consumer accepts y this cycle when out_valid = 1
//   gnt       : one-hot grant, all-zero when idle
//   S         : mux select = index of the granted requester
//   y         : selected data word (d[S]); only meaningful while out_valid = 1
//   out_valid : y holds a granted word
// The master modport is the environment side (requesters and consumer);
// the slave modport is the arbiter side.
// ---------------------------------------------------------------------------
interface mux8_rr_arbiter_if #(
  parameter int WIDTH = 6
);
  logic [7:0]       req;
  logic [WIDTH-1:0] d0;
  logic [WIDTH-1:0] d1;
  logic [WIDTH-1:0] d2;
  logic [WIDTH-1:0] d3;
  logic [WIDTH-1:0] d4;
  logic [WIDTH-1:0] d5;
  logic [WIDTH-1:0] d6;
  logic [WIDTH-1:0] d7;
  logic             out_ready;
  logic [7:0]       gnt;
  logic [2:0]       S;
  logic [WIDTH-1:0] y;
  logic             out_valid;

  modport master (
    output req, d0, d1, d2, d3, d4, d5, d6, d7, out_ready,
    input  gnt, S, y, out_valid
  );

  modport slave (
    input  req, d0, d1, d2, d3, d4, d5, d6, d7, out_ready,
    output gnt, S, y, out_valid
  );
endinterface

// File: rtl/mux8_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mux8_rr_arbiter
// Round-robin arbiter sharing one 8:1 mux among eight requesters. A winner
// is chosen starting just after the last served index, its grant and mux
// select are registered, and the selected word is offered to a single
// consumer with a valid/ready handshake. The grant is held until the word
// is accepted, or dropped if the granted requester withdraws first.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high reset
//   bus   : mux8_rr_arbiter_if.slave (req, d0..d7, out_ready in;
//           gnt, S, y, out_valid out)
// ---------------------------------------------------------------------------
module mux8_rr_arbiter #(
  parameter int WIDTH = 6
) (
  input  logic               clk,
  input  logic               reset,
  mux8_rr_arbiter_if.slave   bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] gnt_q,   gnt_d;
  logic [2:0] s_q,     s_d;
  logic [2:0] last_q,  last_d;

  logic [WIDTH-1:0] y_mux;
  logic [3:0]       pick_idle;
  logic [3:0]       pick_xfer;

  // Returns {found, index}. The scan starts at last+1 and ends at last
  // itself, so the most recently served requester has the lowest priority.
  function automatic logic [3:0] rr_pick(input logic [7:0] r,
                                         input logic [2:0] last);
    logic       found;
    logic [2:0] idx;
    logic [2:0] cand;
    found = 1'b0;
    idx   = 3'd0;
    for (int k = 1; k <= 8; k++) begin
      cand = last + 3'(k);
      if (!found && r[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    return {found, idx};
  endfunction

  // Shared result mux: y follows d[S] at all times, idle included.
  always_comb begin
    y_mux = bus.d0;
    unique case (s_q)
      3'd0: y_mux = bus.d0;
      3'd1: y_mux = bus.d1;
      3'd2: y_mux = bus.d2;
      3'd3: y_mux = bus.d3;
      3'd4: y_mux = bus.d4;
      3'd5: y_mux = bus.d5;
      3'd6: y_mux = bus.d6;
      3'd7: y_mux = bus.d7;
      default: y_mux = bus.d0;
    endcase
  end

  // From IDLE the search is relative to the stored pointer; after a
  // transfer it is relative to the index just served (which becomes last).
  assign pick_idle = rr_pick(bus.req, last_q);
  assign pick_xfer = rr_pick(bus.req, s_q);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    s_d     = s_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (pick_idle[3]) begin
          state_d = GRANT;
          s_d     = pick_idle[2:0];
          gnt_d   = 8'b1 << pick_idle[2:0];
        end
      end
      GRANT: begin
        if (bus.out_ready) begin
          // Accept wins over a simultaneous withdraw of req[S].
          last_d = s_q;
          if (pick_xfer[3]) begin
            s_d   = pick_xfer[2:0];
            gnt_d = 8'b1 << pick_xfer[2:0];
          end else begin
            state_d = IDLE;
            gnt_d   = 8'h00;
          end
        end else if (!bus.req[s_q]) begin
          // Granted requester withdrew before acceptance: drop the grant
          // without advancing the pointer.
          state_d = IDLE;
          gnt_d   = 8'h00;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 8'h00;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= 8'h00;
      s_q     <= 3'd0;
      last_q  <= 3'd7;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      s_q     <= s_d;
      last_q  <= last_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.S         = s_q;
  assign bus.y         = y_mux;
  assign bus.out_valid = (state_q == GRANT);

endmodule
